// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: LSL/LSR/ASR/ROL/ROR plus pass-through, one stage per shamt bit.
// Latency: result on out_* after edge E+N-1 for an input accepted at edge E; 1 op/cycle.
// Backpressure: whole pipe freezes while out_valid && !out_ready; in_ready mirrors that.
module barrel_shifter_pipe #(
    parameter int DATA_W = 32,
    parameter int SH_W   = $clog2(DATA_W),
    parameter int N      = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SH_W-1:0]   in_shamt,
    input  logic [2:0]        in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_zero
);

    localparam logic [2:0] OP_LSL = 3'b000;
    localparam logic [2:0] OP_LSR = 3'b001;
    localparam logic [2:0] OP_ASR = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    logic advance;
    logic zero_q;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    function automatic logic [DATA_W-1:0] shift_step(
        input logic [DATA_W-1:0] x,
        input logic [2:0]        op,
        input logic              sgn,
        input logic              en,
        input int                s
    );
        logic [DATA_W-1:0] res;
        logic [DATA_W-1:0] fill;
        fill = ~({DATA_W{1'b1}} >> s);
        res  = x;
        if (en) begin
            case (op)
                OP_LSL:  res = x << s;
                OP_LSR:  res = x >> s;
                OP_ASR:  res = sgn ? ((x >> s) | fill) : (x >> s);
                OP_ROL:  res = (x << s) | (x >> (DATA_W - s));
                OP_ROR:  res = (x >> s) | (x << (DATA_W - s));
                default: res = x;
            endcase
        end
        return res;
    endfunction

    for (genvar k = 0; k < N; k++) begin : g_stg
        localparam int STEP = 1 << k;

        logic [DATA_W-1:0] src_dat;
        logic [DATA_W-1:0] nxt_dat;
        logic [DATA_W-1:0] dat_q;
        logic [2:0]        src_op;
        logic              src_vld;
        logic              src_sgn;
        logic              src_en;
        logic              vld_q;

        // The sign travels with the operand so ASR fills from the original MSB,
        // not from whatever earlier stages left in the top bit.
        if (k == 0) begin : g_src
            assign src_dat = in_data;
            assign src_vld = in_valid;
            assign src_op  = in_op;
            assign src_sgn = in_data[DATA_W-1];
            assign src_en  = in_shamt[0];
        end else begin : g_src
            assign src_dat = g_stg[k-1].dat_q;
            assign src_vld = g_stg[k-1].vld_q;
            assign src_op  = g_stg[k-1].g_meta.op_q;
            assign src_sgn = g_stg[k-1].g_meta.sgn_q;
            assign src_en  = g_stg[k-1].g_meta.sh_q[0];
        end

        assign nxt_dat = shift_step(src_dat, src_op, src_sgn, src_en, STEP);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dat_q <= '0;
                vld_q <= 1'b0;
            end else if (advance) begin
                dat_q <= nxt_dat;
                vld_q <= src_vld;
            end
        end

        // Stage k keeps only the shamt bits later stages still need.
        if (k < N - 1) begin : g_meta
            localparam int SW = SH_W - 1 - k;

            logic [SW-1:0] sh_q;
            logic [SW-1:0] sh_nxt;
            logic [2:0]    op_q;
            logic          sgn_q;

            if (k == 0) begin : g_sh
                assign sh_nxt = in_shamt[SH_W-1:1];
            end else begin : g_sh
                assign sh_nxt = g_stg[k-1].g_meta.sh_q[SW:1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sh_q  <= '0;
                    op_q  <= '0;
                    sgn_q <= 1'b0;
                end else if (advance) begin
                    sh_q  <= sh_nxt;
                    op_q  <= src_op;
                    sgn_q <= src_sgn;
                end
            end
        end
    end

    // Zero flag is derived from the final stage's next value so it updates on the same edge as out_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b1;
        end else if (advance) begin
            zero_q <= (g_stg[N-1].nxt_dat == '0);
        end
    end

    assign out_valid = g_stg[N-1].vld_q;
    assign out_data  = g_stg[N-1].dat_q;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed bench for barrel_shifter_pipe at DATA_W=8 (three stages).
// Expected results are hand-computed constants held in the vector tables below.
module tb_barrel_shifter_pipe;

    localparam int DW = 8;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [SW-1:0] in_shamt;
    logic [2:0]    in_op;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_zero;

    int n_checks = 0;
    int n_err    = 0;

    // Stream vectors: data, op, shamt, expected result.
    logic [7:0] v_dat [8] = '{8'h01, 8'h81, 8'h81, 8'hF0, 8'h70, 8'hC3, 8'hA5, 8'h3C};
    logic [2:0] v_op  [8] = '{3'd0,  3'd3,  3'd4,  3'd1,  3'd2,  3'd2,  3'd3,  3'd7};
    logic [2:0] v_sh  [8] = '{3'd1,  3'd1,  3'd1,  3'd4,  3'd4,  3'd2,  3'd4,  3'd5};
    logic [7:0] v_exp [8] = '{8'h02, 8'h03, 8'hC0, 8'h0F, 8'h07, 8'hF0, 8'h5A, 8'h3C};

    always #5 clk = ~clk;

    barrel_shifter_pipe #(.DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One isolated op: accepted at edge E, must be absent after E+1 and present after E+2.
    task automatic send_one(input string tag, input logic [7:0] d, input logic [2:0] op,
                            input logic [2:0] sh, input logic [7:0] exp);
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        in_op     = op;
        in_shamt  = sh;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_early"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_dat"}, {24'd0, out_data}, {24'd0, exp});
        check({tag, "_zero"}, {31'd0, out_zero}, {31'd0, (exp == 8'h00)});
    endtask

    // Streams n table vectors back to back; out_ready is low for stall_len cycles from cycle stall_at.
    task automatic run_stream(input string tag, input int n, input int stall_at, input int stall_len);
        int         sent  = 0;
        int         rx    = 0;
        int         first = -1;
        int         last  = -1;
        bit         acc   = 1'b0;
        logic [7:0] held  = 8'h00;
        logic       held_z = 1'b0;
        for (int c = 0; c < n + stall_len + 8; c++) begin
            @(posedge clk); #1;
            if (acc) sent++;
            out_ready = !(c >= stall_at && c < stall_at + stall_len);
            in_valid  = (sent < n);
            if (sent < n) begin
                in_data  = v_dat[sent];
                in_op    = v_op[sent];
                in_shamt = v_sh[sent];
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            if (stall_len == 0 && c < n)
                check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
            if (!out_ready) begin
                check({tag, "_stall_rdy"}, {31'd0, in_ready}, 32'd0);
                check({tag, "_stall_vld"}, {31'd0, out_valid}, 32'd1);
                if (c == stall_at) begin
                    held   = out_data;
                    held_z = out_zero;
                    check({tag, "_stall_head"}, {24'd0, out_data}, {24'd0, v_exp[0]});
                end else begin
                    check({tag, "_stall_dat"}, {24'd0, out_data}, {24'd0, held});
                    check({tag, "_stall_zero"}, {31'd0, out_zero}, {31'd0, held_z});
                end
            end else if (out_valid) begin
                if (rx < n)
                    check({tag, "_dat"}, {24'd0, out_data}, {24'd0, v_exp[rx]});
                else
                    check({tag, "_extra"}, rx, n - 1);
                if (first < 0) first = c;
                last = c;
                rx++;
            end
        end
        check({tag, "_count"}, rx, n);
        if (stall_len == 0) begin
            check({tag, "_first"}, first, 3);
            check({tag, "_span"}, last - first, n - 1);
        end
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        in_op     = '0;
        in_shamt  = '0;
        out_ready = 1'b0;

        // Reset asserted before any clock edge.
        #1 rst_n = 1'b0;
        #2;
        check("rst_vld",  {31'd0, out_valid}, 32'd0);
        check("rst_dat",  {24'd0, out_data},  32'd0);
        check("rst_zero", {31'd0, out_zero},  32'd1);
        check("rst_rdy",  {31'd0, in_ready},  32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_vld",  {31'd0, out_valid}, 32'd0);
        check("idle_dat",  {24'd0, out_data},  32'd0);
        check("idle_zero", {31'd0, out_zero},  32'd1);
        check("idle_rdy",  {31'd0, in_ready},  32'd1);

        send_one("lsl3", 8'h96, 3'd0, 3'd3, 8'hB0);
        send_one("lsr3", 8'h96, 3'd1, 3'd3, 8'h12);
        send_one("asr3", 8'h96, 3'd2, 3'd3, 8'hF2);
        send_one("rol3", 8'h96, 3'd3, 3'd3, 8'hB4);
        send_one("ror3", 8'h96, 3'd4, 3'd3, 8'hD2);
        send_one("rsv3", 8'h96, 3'd6, 3'd3, 8'h96);

        send_one("asr7", 8'h80, 3'd2, 3'd7, 8'hFF);
        send_one("lsl7", 8'h01, 3'd0, 3'd7, 8'h80);
        send_one("lsr1", 8'h01, 3'd1, 3'd1, 8'h00);
        send_one("lsr7", 8'h80, 3'd1, 3'd7, 8'h01);
        send_one("ror7", 8'h5A, 3'd4, 3'd7, 8'hB4);
        for (int op = 0; op < 8; op++) begin
            logic [2:0] op3;
            op3 = op[2:0];
            send_one("sh0", 8'h5A, op3, 3'd0, 8'h5A);
        end

        run_stream("thru", 8, 100, 0);
        run_stream("bp", 6, 3, 4);

        // Fill the pipe with the output held, then reset asynchronously between edges.
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = v_dat[i];
            in_op    = v_op[i];
            in_shamt = v_sh[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_full_vld", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld",  {31'd0, out_valid}, 32'd0);
        check("mid_rst_rdy",  {31'd0, in_ready},  32'd1);
        check("mid_rst_zero", {31'd0, out_zero},  32'd1);
        check("mid_rst_dat",  {24'd0, out_data},  32'd0);
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_vld", {31'd0, out_valid}, 32'd0);
        end
        send_one("post_rst_op", 8'hC3, 3'd2, 3'd2, 8'hF0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
